uart_rx_os16: RTL and testbench

- 8N1 UART receiver with 16x oversampling and a 2-flop input synchroniser.
- Recovers bytes from the serial `rx` line and presents them on a one-entry valid/ready holding register.
- Reports framing errors and overruns as single-cycle pulses.
- Receive-direction companion to the UART transmit path; feeds the RX data/status registers of the Avalon-MM UART slave.

---
 rtl/uart_rx_os16.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver with 16x oversampling, a 2-flop input
// synchroniser, and a one-entry valid/ready holding register. Framing
// errors and overruns are reported as single-cycle pulses.
module uart_rx_os16 #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       os_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;

  logic clr_div, clr_os, clr_bit, shift_en, good_stop, bad_stop;
  logic mid_tick, full_tick, load;

  assign tick      = (div_cnt == clk_div);
  assign mid_tick  = tick && (os_cnt == 4'd7);
  assign full_tick = tick && (os_cnt == 4'd15);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Oversample tick divider; realigned to the start edge on leaving IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clr_div || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    clr_div   = 1'b0;
    clr_os    = 1'b0;
    clr_bit   = 1'b0;
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          clr_div   = 1'b1;
          clr_os    = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a high level here means the falling edge was a glitch.
        if (mid_tick) begin
          if (!rx_s) begin
            state_nxt = DATA;
            clr_os    = 1'b1;
            clr_bit   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            good_stop = 1'b1;
            state_nxt = IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break is one error, not many frames.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tick counter within a bit, and data bit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt  <= '0;
      bit_idx <= '0;
    end else begin
      if (clr_os) begin
        os_cnt <= '0;
      end else if (tick && (state != IDLE) && (state != WAIT_HIGH)) begin
        os_cnt <= os_cnt + 4'd1;
      end
      if (clr_bit) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // LSB-first shift register: new bit enters at the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  // A slot is free if empty or being drained in the same cycle.
  assign load = good_stop && (!rx_valid || rx_ready);

  // Holding register and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good_stop && rx_valid && !rx_ready;
      if (load) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed testbench for uart_rx_os16: glitch rejection, framing error with
// break, overrun, back-to-back frames and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  logic        clk;
  logic        reset_n;
  logic [15:0] clk_div;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;

  int         cyc        = 0;
  int         rise_cyc   = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] got [0:15];
  int         nget       = 0;
  int         frame_cnt  = 0;
  int         ovr_cnt    = 0;
  int         start_cyc  = 0;

  uart_rx_os16 #(.DIV_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_div   (clk_div),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) begin
      if (nget < 16) got[nget] = rx_data;
      nget++;
    end
    if (frame_err) frame_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the edge.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb, input int bitc);
    rx = 1'b0;
    tick_n(bitc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(bitc);
    end
    rx = stopb;
    tick_n(bitc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    clk_div  = 16'd3;
    tick_n(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    tick_n(10);

    // Single byte, latency from the start edge
    start_cyc = cyc;
    send(8'hA5, 1'b1, 64);
    tick_n(128);
    chk("a5_count", nget, 1);
    chk("a5_data", got[0], 8'hA5);
    chk("a5_latency", rise_cyc, start_cyc + 611);
    chk("a5_ferr", frame_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);
    chk("a5_drained", rx_valid, 0);

    // Short low glitch is rejected
    rx = 1'b0;
    tick_n(20);
    rx = 1'b1;
    tick_n(128);
    chk("glitch_count", nget, 1);
    chk("glitch_ferr", frame_cnt, 0);
    send(8'h3C, 1'b1, 64);
    tick_n(128);
    chk("3c_count", nget, 2);
    chk("3c_data", got[1], 8'h3C);

    // Framing error followed by a break
    send(8'h55, 1'b0, 64);
    tick_n(200);
    chk("brk_ferr", frame_cnt, 1);
    chk("brk_count", nget, 2);
    rx = 1'b1;
    tick_n(128);
    chk("brk_ferr_once", frame_cnt, 1);
    send(8'h81, 1'b1, 64);
    tick_n(128);
    chk("81_count", nget, 3);
    chk("81_data", got[2], 8'h81);
    chk("81_ferr", frame_cnt, 1);

    // Overrun while the holding register is full
    rx_ready = 1'b0;
    send(8'h3C, 1'b1, 64);
    tick_n(64);
    send(8'hC3, 1'b1, 64);
    tick_n(128);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_pulse", ovr_cnt, 1);
    chk("ovr_ferr", frame_cnt, 1);
    chk("ovr_count", nget, 3);
    rx_ready = 1'b1;
    tick_n(2);
    chk("drain_valid", rx_valid, 0);
    chk("drain_count", nget, 4);
    chk("drain_data", got[3], 8'h3C);

    // Back-to-back frames at one tick per cycle
    clk_div = 16'd0;
    tick_n(4);
    send(8'h00, 1'b1, 16);
    send(8'hFF, 1'b1, 16);
    send(8'h5A, 1'b1, 16);
    tick_n(64);
    chk("b2b_count", nget, 7);
    chk("b2b_d0", got[4], 8'h00);
    chk("b2b_d1", got[5], 8'hFF);
    chk("b2b_d2", got[6], 8'h5A);
    chk("b2b_ferr", frame_cnt, 1);
    chk("b2b_ovr", ovr_cnt, 1);

    // Reset during data bit 4
    clk_div = 16'd3;
    tick_n(4);
    rx = 1'b0;
    tick_n(64);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick_n(64);
    end
    rx = 1'b0;
    tick_n(30);
    reset_n = 1'b0;
    rx = 1'b1;
    tick_n(2);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovr", overrun, 0);
    tick_n(3);
    reset_n = 1'b1;
    tick_n(200);
    chk("mrst_count", nget, 7);
    chk("mrst_nopulse", frame_cnt + ovr_cnt, 2);
    send(8'h96, 1'b1, 64);
    tick_n(128);
    chk("96_count", nget, 8);
    chk("96_data", got[7], 8'h96);
    chk("96_pulses", frame_cnt + ovr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
